dwt_lift_ctrl: RTL and testbench

Sequencing controller for one row of the LeGall 5/3 integer lifting transform. It drains samples from the upstream sample FIFO through that FIFO's rd_en/empty handshake and applies the predict and update steps, with whole-sample symmetric boundary extension. It emits one approximation/detail coefficient pair per step to the downstream stage under a valid/ready handshake. It sits between the input sample FIFO and the coefficient buffers of the row pass.

---
 rtl/dwt_lift_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dwt_lift_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_lift_ctrl.sv
// LeGall 5/3 row lifting controller: pulls one row of samples from the input
// FIFO and emits one (approximation, detail) coefficient pair per lifting step.
module dwt_lift_ctrl #(
  parameter int unsigned ROW_LEN = 8,
  parameter int unsigned DW      = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_en_o,
  input  logic [DW-1:0] fifo_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_approx_o,
  output logic [DW-1:0] out_detail_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam int unsigned NPAIR = ROW_LEN / 2;
  localparam int unsigned NW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int unsigned LAST  = NPAIR - 1;
  localparam int unsigned EW    = DW + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [1:0]           rd_cnt_q, rd_cnt_d;
  logic                 inflight_q, inflight_d;
  logic signed [DW-1:0] xe_q, xe_d, xo_q, xo_d, xn_q, xn_d, dprev_q, dprev_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        approx_q, approx_d, detail_q, detail_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 first_c, last_c, rd_en_c, pair_full_c;
  logic [1:0]           need_c, slot_c;
  logic signed [EW-1:0] pred_sum_c, d_full_c, upd_c, s_full_c;
  logic signed [DW-1:0] xr_c, d_c, dm1_c, s_c;

  // Read bookkeeping: pair 0 needs x0..x2, the last pair one sample, others two.
  always_comb begin
    first_c     = (n_q == '0);
    last_c      = (n_q == NW'(LAST));
    need_c      = first_c ? 2'd3 : (last_c ? 2'd1 : 2'd2);
    rd_en_c     = (state_q == S_FILL) && !fifo_empty_i && (rd_cnt_q < need_c);
    slot_c      = rd_cnt_q - 2'd1;
    pair_full_c = (state_q == S_FILL) && inflight_q && (rd_cnt_q == need_c);
  end

  // Sample window: capture returning reads, slide x[2n+2] into x[2n] on transfer.
  always_comb begin
    xe_d = xe_q;
    xo_d = xo_q;
    xn_d = xn_q;
    if ((state_q == S_FILL) && inflight_q) begin
      if (first_c) begin
        case (slot_c)
          2'd0:    xe_d = fifo_data_i;
          2'd1:    xo_d = fifo_data_i;
          default: xn_d = fifo_data_i;
        endcase
      end else if (slot_c == 2'd0) begin
        xo_d = fifo_data_i;
      end else begin
        xn_d = fifo_data_i;
      end
    end else if ((state_q == S_EMIT) && out_ready_i && !last_c) begin
      xe_d = xn_q;
    end
  end

  // Predict/update on the window including the sample arriving this cycle.
  always_comb begin
    xr_c       = last_c ? xe_d : xn_d;
    pred_sum_c = EW'(xe_d) + EW'(xr_c);
    d_full_c   = EW'(xo_d) - (pred_sum_c >>> 1);
    d_c        = DW'(d_full_c);
    dm1_c      = first_c ? d_c : dprev_q;
    upd_c      = (EW'(dm1_c) + EW'(d_c) + EW'(2)) >>> 2;
    s_full_c   = EW'(xe_d) + upd_c;
    s_c        = DW'(s_full_c);
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    rd_cnt_d    = rd_cnt_q;
    inflight_d  = rd_en_c;
    dprev_d     = dprev_q;
    out_valid_d = out_valid_q;
    approx_d    = approx_q;
    detail_d    = detail_q;
    if (rd_en_c) rd_cnt_d = rd_cnt_q + 2'd1;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_FILL;
          n_d      = '0;
          rd_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (pair_full_c) begin
          state_d     = S_EMIT;
          out_valid_d = 1'b1;
          approx_d    = s_c;
          detail_d    = d_c;
          dprev_d     = d_c;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (last_c) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_FILL;
            n_d      = n_q + NW'(1);
            rd_cnt_d = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      rd_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      xe_q        <= '0;
      xo_q        <= '0;
      xn_q        <= '0;
      dprev_q     <= '0;
      out_valid_q <= 1'b0;
      approx_q    <= '0;
      detail_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      rd_cnt_q    <= rd_cnt_d;
      inflight_q  <= inflight_d;
      xe_q        <= xe_d;
      xo_q        <= xo_d;
      xn_q        <= xn_d;
      dprev_q     <= dprev_d;
      out_valid_q <= out_valid_d;
      approx_q    <= approx_d;
      detail_q    <= detail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fifo_rd_en_o = rd_en_c;
  assign out_valid_o  = out_valid_q;
  assign out_approx_o = approx_q;
  assign out_detail_o = detail_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
endmodule

// File: tb/tb_dwt_lift_ctrl.sv
// Bench for dwt_lift_ctrl: ROW_LEN=8 and ROW_LEN=4 instances fed from a
// behavioural FIFO, outputs compared with an arithmetic 5/3 lifting model.
module tb_dwt_lift_ctrl;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start[2], fempty[2], oready[2], stall[2];
  logic [DW-1:0] fdata[2];
  logic          rd_en[2], ovalid[2], busy[2], done[2];
  logic [DW-1:0] oa[2], od[2];

  logic          rd_en8, ovalid8, busy8, done8, rd_en4, ovalid4, busy4, done4;
  logic [DW-1:0] oa8, od8, oa4, od4;

  logic [DW-1:0] fmem[2][4096];
  int            rdp[2] = '{0, 0};
  int            wrc[2] = '{0, 0};

  dwt_lift_ctrl #(.ROW_LEN(8), .DW(DW)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .start_i(start[0]), .fifo_empty_i(fempty[0]),
    .fifo_rd_en_o(rd_en8), .fifo_data_i(fdata[0]), .out_valid_o(ovalid8),
    .out_ready_i(oready[0]), .out_approx_o(oa8), .out_detail_o(od8),
    .busy_o(busy8), .done_o(done8)
  );

  dwt_lift_ctrl #(.ROW_LEN(4), .DW(DW)) u_dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start[1]), .fifo_empty_i(fempty[1]),
    .fifo_rd_en_o(rd_en4), .fifo_data_i(fdata[1]), .out_valid_o(ovalid4),
    .out_ready_i(oready[1]), .out_approx_o(oa4), .out_detail_o(od4),
    .busy_o(busy4), .done_o(done4)
  );

  always_comb begin
    rd_en[0] = rd_en8;  ovalid[0] = ovalid8; busy[0] = busy8; done[0] = done8;
    oa[0]    = oa8;     od[0]     = od8;
    rd_en[1] = rd_en4;  ovalid[1] = ovalid4; busy[1] = busy4; done[1] = done4;
    oa[1]    = oa4;     od[1]     = od4;
    for (int k = 0; k < 2; k++) fempty[k] = stall[k] || (rdp[k] >= wrc[k]);
  end

  // FIFO read port: data appears the cycle after an accepted read.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) begin
        fdata[k] <= fmem[k][rdp[k] % 4096];
        rdp[k]   <= rdp[k] + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int xs[16];
  int got_a[8], got_d[8];
  int got_n, reads_seen, done_cnt, first_v;
  int rd_hist[64], busy_hist[64];
  bit rand_ready, rand_stall, hold_mode, start_again, reset_mid, aborted;
  int stall_after;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    logic signed [DW-1:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int wrap(input int v);
    logic signed [DW-1:0] t;
    t = DW'(v);
    return int'(t);
  endfunction

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic check_zero_outputs(input int k, input string tag);
    check({tag, "_rd_en"}, int'(rd_en[k]), 0);
    check({tag, "_valid"}, int'(ovalid[k]), 0);
    check({tag, "_approx"}, int'(oa[k]), 0);
    check({tag, "_detail"}, int'(od[k]), 0);
    check({tag, "_busy"}, int'(busy[k]), 0);
    check({tag, "_done"}, int'(done[k]), 0);
  endtask

  // Runs one row on instance k; entered and left just after a falling edge.
  task automatic run_row(input int k, input int len);
    int  stall_cnt, hold_cnt, stall_v, prev_pair, cur_pair;
    bit  in_stall, in_hold, drop_pending, release_now, prev_vnr, finished, do_reset;
    int  ha, hd;
    wrc[k] = rdp[k];
    for (int i = 0; i < len; i++) fmem[k][(wrc[k] + i) % 4096] = DW'(xs[i]);
    wrc[k] = wrc[k] + len;
    got_n = 0; reads_seen = 0; done_cnt = 0; first_v = -1; aborted = 0;
    stall_cnt = 0; hold_cnt = 0; stall_v = 0; prev_pair = 0; ha = 0; hd = 0;
    drop_pending = 0; prev_vnr = 0; finished = 0; do_reset = 0;
    for (int c = 0; c < 400 && !finished && !aborted; c++) begin
      start[k] = (c == 0) || (start_again && (c == 7 || c == 12));
      stall[k] = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      in_stall = 0;
      if (stall_after >= 0 && reads_seen == stall_after && stall_cnt < 10) begin
        if (stall_cnt == 0) stall_v = int'(ovalid[k]);
        stall[k] = 1'b1;
        in_stall = 1;
        stall_cnt++;
      end
      oready[k] = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_hold = 0; release_now = 0;
      if (hold_mode && ovalid[k] && got_n == 0) begin
        if (hold_cnt == 0) begin ha = int'(oa[k]); hd = int'(od[k]); end
        if (hold_cnt < 5) begin oready[k] = 1'b0; in_hold = 1; end
        else begin oready[k] = 1'b1; release_now = 1; end
        hold_cnt++;
      end
      if (reset_mid && got_n == 1 && reads_seen >= 4 && !ovalid[k]) begin
        reset = 1'b1;
        do_reset = 1;
      end
      #1;
      cur_pair = int'({oa[k], od[k]});
      if (rd_en[k]) reads_seen++;
      if (c < 64) begin rd_hist[c] = int'(rd_en[k]); busy_hist[c] = int'(busy[k]); end
      if (in_stall) begin
        check("stall_rd_en", int'(rd_en[k]), 0);
        check("stall_valid", int'(ovalid[k]), stall_v);
      end
      if (in_hold) begin
        check("hold_rd_en", int'(rd_en[k]), 0);
        check("hold_approx", int'(oa[k]), ha);
        check("hold_detail", int'(od[k]), hd);
      end
      if (drop_pending) begin
        check("valid_drop_after_xfer", int'(ovalid[k]), 0);
        drop_pending = 0;
      end
      if (release_now) drop_pending = 1;
      if (ovalid[k]) begin
        check("no_read_in_emit", int'(rd_en[k]), 0);
        if (first_v < 0) first_v = c;
      end
      if (prev_vnr) begin
        check("stall_valid_held", int'(ovalid[k]), 1);
        check("stall_pair_held", cur_pair, prev_pair);
      end
      prev_vnr  = ovalid[k] && !oready[k];
      prev_pair = cur_pair;
      if (ovalid[k] && oready[k] && got_n < 8) begin
        got_a[got_n] = sx(oa[k]);
        got_d[got_n] = sx(od[k]);
        got_n++;
      end
      if (done[k]) begin
        done_cnt++;
        check("busy_in_done", int'(busy[k]), 1);
        finished = 1;
      end
      @(negedge clk);
      if (do_reset) begin
        reset = 1'b0;
        check_zero_outputs(k, "midrow_reset");
        aborted = 1;
      end
    end
    start[k] = 1'b0; stall[k] = 1'b0; oready[k] = 1'b1;
    if (finished) begin
      check("idle_busy", int'(busy[k]), 0);
      check("done_single_pulse", int'(done[k]), 0);
    end else if (!aborted) begin
      check("row_timeout", 0, 1);
    end
  endtask

  // 5/3 lifting computed directly from the sample list.
  task automatic verify_row(input int len, input string tag);
    int d[8], xe, xo, xn, dm, s;
    check({tag, "_pairs"}, got_n, len / 2);
    check({tag, "_reads"}, reads_seen, len);
    check({tag, "_done_cnt"}, done_cnt, 1);
    for (int n = 0; n < len / 2; n++) begin
      xe   = xs[2*n];
      xo   = xs[2*n+1];
      xn   = (2*n + 2 < len) ? xs[2*n+2] : xs[len-2];
      d[n] = wrap(xo - fdiv(xe + xn, 2));
      dm   = (n == 0) ? d[0] : d[n-1];
      s    = wrap(xe + fdiv(dm + d[n] + 2, 4));
      check($sformatf("%s_s%0d", tag, n), got_a[n], s);
      check($sformatf("%s_d%0d", tag, n), got_d[n], d[n]);
    end
  endtask

  task automatic clear_modes();
    rand_ready = 0; rand_stall = 0; hold_mode = 0; start_again = 0;
    reset_mid = 0; stall_after = -1;
  endtask

  task automatic random_row(input int len, input int span);
    for (int i = 0; i < len; i++) xs[i] = int'($urandom_range(0, 2*span - 1)) - span;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; oready[k] = 1'b1; stall[k] = 1'b0;
    end
    clear_modes();
    repeat (3) @(negedge clk);
    check_zero_outputs(0, "reset8");
    check_zero_outputs(1, "reset4");
    reset = 1'b0;
    @(negedge clk);

    // Ramp row: known pairs, latency and read pattern.
    for (int i = 0; i < 8; i++) xs[i] = 10 * (i + 1);
    run_row(0, 8);
    verify_row(8, "ramp");
    check("ramp_first_valid", first_v, 5);
    check("ramp_rd_T0", rd_hist[0], 0);
    check("ramp_rd_T1", rd_hist[1], 1);
    check("ramp_rd_T2", rd_hist[2], 1);
    check("ramp_rd_T3", rd_hist[3], 1);
    check("ramp_rd_T4", rd_hist[4], 0);
    check("ramp_busy_T0", busy_hist[0], 0);
    check("ramp_busy_T1", busy_hist[1], 1);
    check("ramp_s3_lit", got_a[3], 73);
    check("ramp_d3_lit", got_d[3], 10);

    // Negative floors and left-edge extension.
    xs[0] = 0; xs[1] = -3; xs[2] = 0; xs[3] = 5;
    run_row(1, 4);
    verify_row(4, "neg");
    check("neg_s0_lit", got_a[0], -1);
    check("neg_d0_lit", got_d[0], -3);

    // Full-scale wrap.
    xs[0] = -32768; xs[1] = 32767; xs[2] = -32768; xs[3] = 32767;
    run_row(1, 4);
    verify_row(4, "wrap");
    check("wrap_d0_lit", got_d[0], -1);
    check("wrap_s1_lit", got_a[1], -32768);

    // FIFO empty for 10 cycles after the 4th read.
    stall_after = 4;
    random_row(8, 32768);
    run_row(0, 8);
    verify_row(8, "fifo_stall");
    clear_modes();

    // Downstream back-pressure on the first pair.
    hold_mode = 1;
    random_row(8, 1000);
    run_row(0, 8);
    verify_row(8, "backpressure");
    clear_modes();

    // Reset during pair 1, then a fresh row with spurious start pulses.
    reset_mid = 1;
    random_row(8, 32768);
    run_row(0, 8);
    check("reset_aborted", int'(aborted), 1);
    clear_modes();
    start_again = 1;
    random_row(8, 32768);
    run_row(0, 8);
    verify_row(8, "after_reset");
    clear_modes();

    // Randomised rows with random stalls and back-pressure on both sizes.
    for (int r = 0; r < 6; r++) begin
      rand_ready = 1; rand_stall = 1;
      random_row(8, (r % 2 == 0) ? 32768 : 8);
      run_row(0, 8);
      verify_row(8, $sformatf("rand8_%0d", r));
      random_row(4, (r % 2 == 0) ? 32768 : 8);
      run_row(1, 4);
      verify_row(4, $sformatf("rand4_%0d", r));
    end
    clear_modes();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
